// File: rtl/booth_final_adder_if.sv
// Handshake bundle between the Booth compressor, the final adder and the product consumer.
// Optional flag signals exist only when BOOTH_FA_FLAGS_EN is defined.
interface booth_final_adder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pp_sum;
  logic [13:0] pp_carry;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
`ifdef BOOTH_FA_FLAGS_EN
  logic        product_zero;
  logic        product_neg;

  modport master (
    output in_valid, pp_sum, pp_carry, out_ready,
    input  in_ready, out_valid, product, product_zero, product_neg
  );
  modport slave (
    input  in_valid, pp_sum, pp_carry, out_ready,
    output in_ready, out_valid, product, product_zero, product_neg
  );
`else
  modport master (
    output in_valid, pp_sum, pp_carry, out_ready,
    input  in_ready, out_valid, product
  );
  modport slave (
    input  in_valid, pp_sum, pp_carry, out_ready,
    output in_ready, out_valid, product
  );
`endif
endinterface

// File: rtl/booth_final_adder.sv
// Two-stage carry-propagate adder resolving the Booth compressor sum/carry pair into the product.
// Define BOOTH_FA_FLAGS_EN to add registered product_zero / product_neg outputs.
module booth_final_adder (
  input  logic               clk,
  input  logic               rst,
  booth_final_adder_if.slave bus
);

  logic        r_s1_valid;
  logic        r_s2_valid;
  logic [8:0]  r_lo;
  logic [7:0]  r_a_hi;
  logic [7:0]  r_b_hi;
  logic [15:0] r_product;

  logic [15:0] w_op_b;
  logic        w_s2_adv;
  logic        w_accept;
  logic [8:0]  w_lo_next;
  logic [7:0]  w_hi_next;
  logic [15:0] w_prod_next;

  assign w_op_b      = {bus.pp_carry, 2'b00};
  assign w_s2_adv    = r_s1_valid && (!r_s2_valid || bus.out_ready);
  assign bus.in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept    = bus.in_valid && bus.in_ready;

  // Low byte resolves in S1; its carry-out feeds the high-byte add in S2.
  assign w_lo_next   = {1'b0, bus.pp_sum[7:0]} + {1'b0, w_op_b[7:0]};
  assign w_hi_next   = r_a_hi + r_b_hi + {7'd0, r_lo[8]};
  assign w_prod_next = {w_hi_next, r_lo[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_lo       <= 9'd0;
      r_a_hi     <= 8'd0;
      r_b_hi     <= 8'd0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_lo       <= w_lo_next;
        r_a_hi     <= bus.pp_sum[15:8];
        r_b_hi     <= w_op_b[15:8];
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_product  <= 16'h0000;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= 1'b1;
        r_product  <= w_prod_next;
      end else if (bus.out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.product   = r_product;

`ifdef BOOTH_FA_FLAGS_EN
  logic r_zero;
  logic r_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
    end else if (w_s2_adv) begin
      r_zero <= (w_prod_next == 16'h0000);
      r_neg  <= w_prod_next[15];
    end
  end

  assign bus.product_zero = r_zero;
  assign bus.product_neg  = r_neg;
`endif

endmodule

// File: tb/tb_booth_final_adder.sv
// Randomised and directed bench for booth_final_adder against a queue-based arithmetic model.
// Flag checks are compiled in when BOOTH_FA_FLAGS_EN is defined.
module tb_booth_final_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  booth_final_adder_if bus ();

  booth_final_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] s, input logic [13:0] c);
    int unsigned full;
    full = int'(s) + int'(c) * 4;
    return full[15:0];
  endfunction

  // Scoreboard: every visible result must equal the oldest outstanding accepted pair.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_out", 32'(bus.out_valid), 32'd0);
        end else begin
          check("product", 32'(bus.product), 32'(exp_q[0]));
`ifdef BOOTH_FA_FLAGS_EN
          check("zero_flag", 32'(bus.product_zero), 32'(exp_q[0] == 16'h0000));
          check("neg_flag", 32'(bus.product_neg), 32'(exp_q[0][15]));
`endif
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.pp_sum, bus.pp_carry));
    end
  end

  // Offers one pair and returns #1 after the edge that accepted it.
  task automatic push(input logic [15:0] s, input logic [13:0] c);
    bit ok = 1'b0;
    bus.pp_sum   = s;
    bus.pp_carry = c;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [15:0] s, input logic [13:0] c,
                          input logic [15:0] exp);
    push(s, c);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, 32'(bus.product), 32'(exp));
`ifdef BOOTH_FA_FLAGS_EN
    check({tag, "_z"}, 32'(bus.product_zero), 32'(exp == 16'h0000));
    check({tag, "_n"}, 32'(bus.product_neg), 32'(exp[15]));
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ov"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_prod"}, 32'(bus.product), 32'h0000);
    check({tag, "_ir"}, 32'(bus.in_ready), 32'd1);
`ifdef BOOTH_FA_FLAGS_EN
    check({tag, "_z"}, 32'(bus.product_zero), 32'd1);
    check({tag, "_n"}, 32'(bus.product_neg), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.in_valid  = 1'b0;
    bus.pp_sum    = '0;
    bus.pp_carry  = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Latency: not visible one edge after accept, visible after the next.
    bus.pp_sum = 16'h0010;
    bus.pp_carry = 14'h0004;
    push(16'h0010, 14'h0004);
    check("lat_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    check("basic", 32'(bus.product), 32'h0020);
    drain();

    directed("c8", 16'h00FF, 14'h0001, 16'h0103);
    directed("wrap", 16'hFFFF, 14'h0001, 16'h0003);
    directed("neg", 16'hFFF0, 14'h0000, 16'hFFF0);
    directed("zero", 16'hFFFC, 14'h0001, 16'h0000);
    drain();

    // Backpressure: two accepts fill the pipe, third pair must wait.
    bus.out_ready = 1'b0;
    push(16'h0001, 14'h0000);
    push(16'h0002, 14'h0000);
    bus.pp_sum = 16'h0003;
    bus.pp_carry = 14'h0000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    push(16'h0003, 14'h0000);
    push(16'h0000, 14'h0001);
    drain();

    // Streaming: back-to-back accepts, drained two edges after the last one.
    t0 = cyc;
    for (int i = 0; i < 64; i++) push(16'($urandom), 14'($urandom));
    check("stream_rate", 32'(cyc - t0), 32'd64);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("stream_drain", 32'(exp_q.size()), 32'd0);

    // Reset with two results in flight: both must vanish.
    bus.out_ready = 1'b0;
    push(16'h1234, 14'h0011);
    push(16'h0F0F, 14'h0101);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("midrst");
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_quiet", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
